// File: rtl/fp_add_arbiter.sv
// Four-way round-robin front end that time-shares one multi-cycle FP adder.
// Optional watchdog on the adder wait: define FP_ADD_ARBITER_TIMEOUT_EN.
module fp_add_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  FP_OPCODE      = 8'd253
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req_valid,
    input  logic [127:0] req_dataa,
    input  logic [127:0] req_datab,
    output logic [3:0]   req_ready,
    output logic [3:0]   rsp_valid,
    output logic [31:0]  rsp_result,
    output logic         rsp_error,
    output logic         fp_start,
    output logic         fp_clk_en,
    output logic [31:0]  fp_dataa,
    output logic [31:0]  fp_datab,
    output logic [7:0]   fp_n,
    input  logic         fp_done,
    input  logic [31:0]  fp_result,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  last_served;
    logic [1:0]  index;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result_q;
    logic        grant_found;
    logic [1:0]  grant_idx;
    logic [1:0]  cand;
    logic        timed_out;

    // Search starts one past the last requester served so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_served + 2'(k);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

`ifdef FP_ADD_ARBITER_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] wait_count;
    logic          error_q;

    assign timed_out = (state == WAIT) && !fp_done &&
                       (wait_count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_count <= '0;
            error_q    <= 1'b0;
        end else if (state == ISSUE) begin
            wait_count <= '0;
            error_q    <= 1'b0;
        end else if (state == WAIT) begin
            if (fp_done) begin
                error_q <= 1'b0;
            end else if (timed_out) begin
                error_q <= 1'b1;
            end else begin
                wait_count <= wait_count + 1'b1;
            end
        end
    end

    assign rsp_error = (state == RESP) && error_q;
`else
    assign timed_out = 1'b0;
    assign rsp_error = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (fp_done || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A timeout substitutes a quiet NaN so the requester still gets a response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_served <= 2'd3;
            index       <= 2'd0;
            op_a        <= '0;
            op_b        <= '0;
            result_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        index <= grant_idx;
                        op_a  <= req_dataa[{grant_idx, 5'd0} +: 32];
                        op_b  <= req_datab[{grant_idx, 5'd0} +: 32];
                    end
                end
                WAIT: begin
                    if (fp_done) begin
                        result_q <= fp_result;
                    end else if (timed_out) begin
                        result_q <= 32'h7FC0_0000;
                    end
                end
                RESP:    last_served <= index;
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == IDLE && grant_found) ? (4'b0001 << grant_idx) : 4'b0000;
    assign rsp_valid  = (state == RESP) ? (4'b0001 << index) : 4'b0000;
    assign rsp_result = (state == RESP) ? result_q : 32'd0;
    assign fp_start   = (state == ISSUE);
    assign fp_clk_en  = (state == ISSUE) || (state == WAIT);
    assign fp_dataa   = op_a;
    assign fp_datab   = op_b;
    assign fp_n       = FP_OPCODE;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a behavioural FP adder stand-in.
// The timeout scenario follows FP_ADD_ARBITER_TIMEOUT_EN as the RTL does.
module tb_fp_add_arbiter;

    localparam int MAX_WAIT = 60;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_dataa;
    logic [127:0] req_datab;
    logic [3:0]   req_ready;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_result;
    logic         rsp_error;
    logic         fp_start;
    logic         fp_clk_en;
    logic [31:0]  fp_dataa;
    logic [31:0]  fp_datab;
    logic [7:0]   fp_n;
    logic         fp_done;
    logic [31:0]  fp_result;
    logic         busy;

    logic         model_en;
    int           model_latency;
    logic         model_done;
    logic [31:0]  model_result;
    logic [31:0]  model_a;
    logic [31:0]  model_b;
    logic         manual_done;
    logic [31:0]  manual_result;

    int           checks;
    int           errors;
    logic         saw_rsp;

    fp_add_arbiter #(
        .TIMEOUT_CYCLES (8),
        .FP_OPCODE      (8'd253)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_dataa  (req_dataa),
        .req_datab  (req_datab),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .fp_start   (fp_start),
        .fp_clk_en  (fp_clk_en),
        .fp_dataa   (fp_dataa),
        .fp_datab   (fp_datab),
        .fp_n       (fp_n),
        .fp_done    (fp_done),
        .fp_result  (fp_result),
        .busy       (busy)
    );

    assign fp_done   = model_done | manual_done;
    assign fp_result = model_done ? model_result : manual_result;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder stand-in: 1.0+2.0 gives the real sum, any other pair returns A^B.
    always begin
        @(negedge clk);
        if (model_en && fp_start) begin
            model_a = fp_dataa;
            model_b = fp_datab;
            repeat (model_latency) @(posedge clk);
            #1;
            model_result = (model_a == 32'h3F80_0000 && model_b == 32'h4000_0000) ?
                           32'h4040_0000 : (model_a ^ model_b);
            model_done = 1'b1;
            @(posedge clk);
            #1;
            model_done = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid);
        @(posedge clk);
        #1;
        req_valid = valid;
    endtask

    task automatic doTransaction(input int idx, input logic [31:0] exp_res,
                                 input logic exp_err, input int exp_wait,
                                 input int exp_lat);
        int         waited;
        int         lat;
        logic [3:0] exp_onehot;
        exp_onehot = 4'b0001 << idx;
        waited = 0;
        while (req_ready == 4'b0000 && waited < MAX_WAIT) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("grant", {28'd0, req_ready}, {28'd0, exp_onehot});
        if (exp_wait >= 0) checkOutput("grant_wait", waited, exp_wait);
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
        @(negedge clk);
        lat = 1;
        checkOutput("fp_start", {31'd0, fp_start}, 32'd1);
        while (rsp_valid == 4'b0000 && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
        end
        if (exp_lat >= 0) checkOutput("latency", lat, exp_lat);
        checkOutput("rsp_valid", {28'd0, rsp_valid}, {28'd0, exp_onehot});
        checkOutput("rsp_result", rsp_result, exp_res);
        checkOutput("rsp_error", {31'd0, rsp_error}, {31'd0, exp_err});
        checkOutput("no_grant_in_resp", {28'd0, req_ready}, 32'd0);
        @(negedge clk);
        checkOutput("rsp_one_cycle", {28'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        req_valid     = 4'b0000;
        req_dataa     = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        req_datab     = {4{32'h0F0F_0F0F}};
        model_en      = 1'b1;
        model_latency = 5;
        model_done    = 1'b0;
        model_result  = 32'd0;
        manual_done   = 1'b0;
        manual_result = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_ready", {28'd0, req_ready}, 32'd0);
        checkOutput("reset_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        checkOutput("reset_fp_start", {31'd0, fp_start}, 32'd0);
        checkOutput("reset_fp_clk_en", {31'd0, fp_clk_en}, 32'd0);
        checkOutput("reset_fp_dataa", fp_dataa, 32'd0);
        checkOutput("fp_n", {24'd0, fp_n}, 32'd253);

        // Single add: 1.0 + 2.0 with a 5-cycle adder.
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        req_dataa[31:0] = 32'h3F80_0000;
        req_datab[31:0] = 32'h4000_0000;
        req_valid       = 4'b0001;
        @(negedge clk);
        doTransaction(0, 32'h4040_0000, 1'b0, 0, 7);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        // All four pending from reset release: strict 0,1,2,3 rotation.
        req_dataa[31:0] = 32'h1111_1111;
        req_datab[31:0] = 32'h0F0F_0F0F;
        model_latency   = 2;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = 4'b1111;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        doTransaction(0, 32'h1E1E_1E1E, 1'b0, 0, 4);
        doTransaction(1, 32'h2D2D_2D2D, 1'b0, -1, -1);
        doTransaction(2, 32'h3C3C_3C3C, 1'b0, -1, -1);
        doTransaction(3, 32'h4B4B_4B4B, 1'b0, -1, -1);

        // Serve 2, then 0 and 2 pending: rotation wraps to 0 first.
        applyStimulus(4'b0100);
        @(negedge clk);
        doTransaction(2, 32'h3C3C_3C3C, 1'b0, -1, -1);
        applyStimulus(4'b0101);
        @(negedge clk);
        doTransaction(0, 32'h1E1E_1E1E, 1'b0, -1, -1);
        doTransaction(2, 32'h3C3C_3C3C, 1'b0, -1, -1);

        // Reset two cycles into WAIT drops the operation; a late done is ignored.
        model_en = 1'b0;
        applyStimulus(4'b0010);
        @(negedge clk);
        checkOutput("grant_pre_reset", {28'd0, req_ready}, 32'h2);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        repeat (3) @(negedge clk);
        checkOutput("in_wait_clk_en", {31'd0, fp_clk_en}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midwait_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midwait_reset_clk_en", {31'd0, fp_clk_en}, 32'd0);
        checkOutput("midwait_reset_dataa", fp_dataa, 32'd0);
        @(posedge clk);
        #1;
        reset         = 1'b0;
        manual_result = 32'hDEAD_BEEF;
        manual_done   = 1'b1;
        @(negedge clk);
        checkOutput("late_done_rsp", {28'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        manual_done = 1'b0;
        @(negedge clk);
        checkOutput("late_done_rsp2", {28'd0, rsp_valid}, 32'd0);
        checkOutput("late_done_busy", {31'd0, busy}, 32'd0);
        model_en = 1'b1;
        applyStimulus(4'b1001);
        @(negedge clk);
        doTransaction(0, 32'h1E1E_1E1E, 1'b0, 0, -1);
        doTransaction(3, 32'h4B4B_4B4B, 1'b0, -1, -1);

        // Stray done while idle changes nothing.
        model_en = 1'b0;
        @(posedge clk);
        #1;
        manual_done = 1'b1;
        @(negedge clk);
        checkOutput("idle_done_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        manual_done = 1'b0;
        @(negedge clk);
        checkOutput("idle_done_rsp", {28'd0, rsp_valid}, 32'd0);
        checkOutput("idle_done_busy2", {31'd0, busy}, 32'd0);

        // Adder that never finishes.
        applyStimulus(4'b0100);
        @(negedge clk);
`ifdef FP_ADD_ARBITER_TIMEOUT_EN
        doTransaction(2, 32'h7FC0_0000, 1'b1, 0, 10);
`else
        checkOutput("hang_grant", {28'd0, req_ready}, 32'h4);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        saw_rsp   = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid != 4'b0000) saw_rsp = 1'b1;
        end
        checkOutput("hang_no_rsp", {31'd0, saw_rsp}, 32'd0);
        checkOutput("hang_busy", {31'd0, busy}, 32'd1);
        checkOutput("hang_clk_en", {31'd0, fp_clk_en}, 32'd1);
        @(posedge clk);
        #1;
        manual_result = 32'h1234_5678;
        manual_done   = 1'b1;
        @(posedge clk);
        #1;
        manual_done = 1'b0;
        @(negedge clk);
        checkOutput("hang_release_valid", {28'd0, rsp_valid}, 32'h4);
        checkOutput("hang_release_result", rsp_result, 32'h1234_5678);
        checkOutput("hang_release_error", {31'd0, rsp_error}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
